// File: rtl/vga_sync_gen_pkg.sv
// Shared VGA timing defaults (640x480@72, 832x520 total) and sync-polarity helpers
// used by the sync generator and by the parallax scene logic.
package vga_sync_gen_pkg;

  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FP     = 24;
  localparam int unsigned DEF_H_SYNC   = 40;
  localparam int unsigned DEF_H_BP     = 128;

  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FP     = 9;
  localparam int unsigned DEF_V_SYNC   = 3;
  localparam int unsigned DEF_V_BP     = 28;

  localparam int unsigned DEF_CW  = 10;
  localparam int unsigned FRAME_W = 8;
  localparam int unsigned RGB_W   = 3;

  // SYNC_POL is the asserted level of hsync/vsync; the idle level is its inverse.
  localparam logic SYNC_ACTIVE_LOW  = 1'b0;
  localparam logic SYNC_ACTIVE_HIGH = 1'b1;

  // Registered output bundle; all three fields move together, one pixel behind x/y.
  typedef struct packed {
    logic             hsync;
    logic             vsync;
    logic [RGB_W-1:0] rgb;
  } vga_out_t;

  function automatic logic sync_level(input logic pol, input logic in_sync);
    return in_sync ? pol : ~pol;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis: a wrapping position counter with active and sync-window decode.
// Used once per line (horizontal) and once per frame (vertical).
module vga_axis_counter #(
  parameter int unsigned ACTIVE = 640,
  parameter int unsigned FP     = 24,
  parameter int unsigned SYNC   = 40,
  parameter int unsigned BP     = 128,
  parameter int unsigned CW     = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  output logic [CW-1:0] cnt,
  output logic          wrap,
  output logic          in_active,
  output logic          in_sync
);

  localparam int unsigned TOTAL = ACTIVE + FP + SYNC + BP;

  // Inclusive bounds keep every constant below TOTAL, so they fit CW even when TOTAL == 2**CW.
  localparam logic [CW-1:0] CNT_LAST    = CW'(TOTAL - 1);
  localparam logic [CW-1:0] ACTIVE_LAST = CW'(ACTIVE - 1);
  localparam logic [CW-1:0] SYNC_FIRST  = CW'(ACTIVE + FP);
  localparam logic [CW-1:0] SYNC_LAST   = CW'(ACTIVE + FP + SYNC - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          at_last;

  always_comb begin
    at_last = (cnt_q == CNT_LAST);
    cnt_d   = cnt_q;
    if (inc) begin
      cnt_d = at_last ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // wrap is qualified by inc so it can directly clock the next axis.
  assign cnt       = cnt_q;
  assign wrap      = inc && at_last;
  assign in_active = (cnt_q <= ACTIVE_LAST);
  assign in_sync   = (cnt_q >= SYNC_FIRST) && (cnt_q <= SYNC_LAST);

endmodule

// File: rtl/vga_sync_gen.sv
// VGA timing generator: x/y counters, frame counter, and a registered hsync/vsync/rgb
// stage that lags the coordinates by exactly one pixel.
module vga_sync_gen
  import vga_sync_gen_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP,
  parameter logic        SYNC_POL = SYNC_ACTIVE_LOW,
  parameter int unsigned CW       = DEF_CW
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  input  logic               pix_en,
  input  logic [RGB_W-1:0]   rgb_in,
  output logic [CW-1:0]      x,
  output logic [CW-1:0]      y,
  output logic               active,
  output logic               line_start,
  output logic               frame_start,
  output logic [FRAME_W-1:0] frame_cnt,
  output logic               hsync,
  output logic               vsync,
  output logic [RGB_W-1:0]   rgb
);

  localparam vga_out_t OUT_RESET = '{
    hsync: sync_level(SYNC_POL, 1'b0),
    vsync: sync_level(SYNC_POL, 1'b0),
    rgb:   '0
  };

  logic h_wrap;
  logic h_in_active;
  logic h_in_sync;
  logic v_wrap;
  logic v_in_active;
  logic v_in_sync;

  vga_axis_counter #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP),
    .CW     (CW)
  ) u_h_cnt (
    .clk       (wb_clk_i),
    .rst       (wb_rst_i),
    .inc       (pix_en),
    .cnt       (x),
    .wrap      (h_wrap),
    .in_active (h_in_active),
    .in_sync   (h_in_sync)
  );

  // v_wrap therefore fires only on the last pixel of the last line: the frame boundary.
  vga_axis_counter #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP),
    .CW     (CW)
  ) u_v_cnt (
    .clk       (wb_clk_i),
    .rst       (wb_rst_i),
    .inc       (pix_en & h_wrap),
    .cnt       (y),
    .wrap      (v_wrap),
    .in_active (v_in_active),
    .in_sync   (v_in_sync)
  );

  assign active      = h_in_active && v_in_active;
  assign line_start  = (x == '0);
  assign frame_start = (x == '0) && (y == '0);

  vga_out_t             out_q;
  vga_out_t             out_d;
  logic [FRAME_W-1:0]   frame_cnt_q;
  logic [FRAME_W-1:0]   frame_cnt_d;

  always_comb begin
    out_d       = out_q;
    frame_cnt_d = frame_cnt_q;
    if (pix_en) begin
      out_d.hsync = sync_level(SYNC_POL, h_in_sync);
      out_d.vsync = sync_level(SYNC_POL, v_in_sync);
      out_d.rgb   = active ? rgb_in : '0;
    end
    if (v_wrap) begin
      frame_cnt_d = frame_cnt_q + FRAME_W'(1);
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      out_q       <= OUT_RESET;
      frame_cnt_q <= '0;
    end else begin
      out_q       <= out_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign hsync     = out_q.hsync;
  assign vsync     = out_q.vsync;
  assign rgb       = out_q.rgb;
  assign frame_cnt = frame_cnt_q;

endmodule
